// File: rtl/sweep_result_buffer.sv
// Captures per-point sweep measurements into four parallel RAMs and, on sweep
// completion, streams them out as 5 words per point over a valid/ready port.
module sweep_result_buffer #(
   parameter int          N_POINTS   = 200,
   parameter int          ADDR_WIDTH = 8,
   parameter logic [15:0] HDR_TAG    = 16'hA55A
) (
   input  logic                  clk125,
   input  logic                  areset_n,
   input  logic                  fin2,
   input  logic                  fin,
   input  logic [ADDR_WIDTH-1:0] address_mem,
   input  logic signed [31:0]    MODULOA,
   input  logic signed [31:0]    MODULOB,
   input  logic signed [31:0]    MODULO,
   input  logic signed [31:0]    PHASE,
   output logic [31:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   point_count,
   output logic                  overflow,
   output logic                  seq_err,
   output logic                  sweep_done
);

   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] RD      = 2'd1;
   localparam logic [1:0] SHOW    = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   localparam logic [ADDR_WIDTH:0] N_PTS = (ADDR_WIDTH+1)'(N_POINTS);

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [2:0]            wsel;

   logic signed [31:0] mem_a  [N_POINTS];
   logic signed [31:0] mem_b  [N_POINTS];
   logic signed [31:0] mem_m  [N_POINTS];
   logic signed [31:0] mem_ph [N_POINTS];

   logic                  cap_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [ADDR_WIDTH:0]   count_next;
   logic                  last_word;
   logic [7:0]            hdr_idx;
   logic [31:0]           word_sel;

   assign wr_addr    = point_count[ADDR_WIDTH-1:0];
   assign cap_en     = (state == COLLECT) && fin2 && (point_count < N_PTS);
   // fin in the same cycle as a capture must see the incremented count
   assign count_next = point_count + (ADDR_WIDTH+1)'(cap_en);
   assign last_word  = (wsel == 3'd4) && ({1'b0, rd_idx} == point_count - 1'b1);
   assign hdr_idx    = 8'(rd_idx);

   always_ff @(posedge clk125) begin
      if (cap_en) begin
         mem_a[wr_addr]  <= MODULOA;
         mem_b[wr_addr]  <= MODULOB;
         mem_m[wr_addr]  <= MODULO;
         mem_ph[wr_addr] <= PHASE;
      end
   end

   always_comb begin
      word_sel = {HDR_TAG, 8'h00, hdr_idx};
      case (wsel)
         3'd1:    word_sel = mem_a[rd_idx];
         3'd2:    word_sel = mem_b[rd_idx];
         3'd3:    word_sel = mem_m[rd_idx];
         3'd4:    word_sel = mem_ph[rd_idx];
         default: word_sel = {HDR_TAG, 8'h00, hdr_idx};
      endcase
   end

   always_ff @(posedge clk125) begin
      if (!areset_n) begin
         state       <= COLLECT;
         out_data    <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         busy        <= 1'b0;
         point_count <= '0;
         overflow    <= 1'b0;
         seq_err     <= 1'b0;
         sweep_done  <= 1'b0;
         rd_idx      <= '0;
         wsel        <= '0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            COLLECT: begin
               if (cap_en) begin
                  point_count <= count_next;
                  if (address_mem != wr_addr)
                     seq_err <= 1'b1;
               end
               if (fin2 && (point_count >= N_PTS))
                  overflow <= 1'b1;
               if (fin && (count_next != '0)) begin
                  state  <= RD;
                  rd_idx <= '0;
                  wsel   <= '0;
                  busy   <= 1'b1;
               end
            end
            // read stage: RAM address applied, selected word registered for SHOW
            RD: begin
               out_data  <= word_sel;
               out_valid <= 1'b1;
               out_last  <= last_word;
               state     <= SHOW;
            end
            SHOW: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (last_word) begin
                     state       <= DONE;
                     wsel        <= '0;
                     busy        <= 1'b0;
                     point_count <= '0;
                     sweep_done  <= 1'b1;
                  end else begin
                     state <= RD;
                     if (wsel == 3'd4) begin
                        wsel   <= '0;
                        rd_idx <= rd_idx + 1'b1;
                     end else begin
                        wsel <= wsel + 3'd1;
                     end
                  end
               end
            end
            default: state <= COLLECT;
         endcase
         if ((state != COLLECT) && fin2)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sweep_result_buffer.sv
// Directed bench for sweep_result_buffer: captures, streaming, backpressure,
// overflow, sequence errors, same-cycle fin/fin2 and mid-stream reset.
module tb_sweep_result_buffer;

   logic               clk125;
   logic               areset_n;
   logic               fin2;
   logic               fin;
   logic [7:0]         address_mem;
   logic signed [31:0] MODULOA;
   logic signed [31:0] MODULOB;
   logic signed [31:0] MODULO;
   logic signed [31:0] PHASE;
   logic [31:0]        out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic               busy;
   logic [8:0]         point_count;
   logic               overflow;
   logic               seq_err;
   logic               sweep_done;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_a[$];
   logic [31:0] m_b[$];
   logic [31:0] m_m[$];
   logic [31:0] m_p[$];
   logic [31:0] got_d[$];
   logic        got_l[$];

   sweep_result_buffer #(.N_POINTS(200), .ADDR_WIDTH(8), .HDR_TAG(16'hA55A)) dut (
      .clk125(clk125), .areset_n(areset_n), .fin2(fin2), .fin(fin),
      .address_mem(address_mem), .MODULOA(MODULOA), .MODULOB(MODULOB),
      .MODULO(MODULO), .PHASE(PHASE), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .busy(busy),
      .point_count(point_count), .overflow(overflow), .seq_err(seq_err),
      .sweep_done(sweep_done)
   );

   initial clk125 = 1'b0;
   always #5 clk125 = ~clk125;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk125);
      #1;
   endtask

   task automatic capture(input logic [7:0] addr, input logic signed [31:0] a,
                          input logic signed [31:0] b, input logic signed [31:0] m,
                          input logic signed [31:0] p, input bit with_fin);
      address_mem = addr;
      MODULOA = a; MODULOB = b; MODULO = m; PHASE = p;
      fin2 = 1'b1;
      fin  = with_fin;
      tick();
      fin2 = 1'b0;
      fin  = 1'b0;
      if (m_a.size() < 200) begin
         m_a.push_back(a); m_b.push_back(b); m_m.push_back(m); m_p.push_back(p);
      end
   endtask

   task automatic clear_model();
      m_a.delete(); m_b.delete(); m_m.delete(); m_p.delete();
   endtask

   // Leaves the bench one cycle into the stream (RD state)
   task automatic pulse_fin();
      fin = 1'b1;
      tick();
      fin = 1'b0;
   endtask

   task automatic run_stream(input string tag, input bit rnd);
      int          last_hs = -100;
      bit          prev_stall = 1'b0;
      bit          done_seen = 1'b0;
      bit          rdy;
      logic [32:0] prev_word = '0;
      got_d.delete();
      got_l.delete();
      for (int i = 0; i < 20000 && !done_seen; i++) begin
         tick();
         if (prev_stall)
            chk($sformatf("%s_hold", tag), {out_valid, out_last, out_data}, {1'b1, prev_word});
         if (sweep_done) begin
            done_seen  = 1'b1;
            prev_stall = 1'b0;
            chk($sformatf("%s_done_timing", tag), i, last_hs + 1);
            chk($sformatf("%s_pc_after", tag), point_count, 0);
            chk($sformatf("%s_busy_after", tag), busy, 0);
         end else begin
            rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
               got_d.push_back(out_data);
               got_l.push_back(out_last);
               last_hs = i;
            end
            prev_stall = out_valid && !rdy;
            prev_word  = {out_last, out_data};
         end
      end
      chk($sformatf("%s_done_seen", tag), done_seen, 1);
      out_ready = 1'b1;
      tick();
   endtask

   task automatic check_stream(input string tag);
      int          n;
      int          pt;
      int          w;
      logic [31:0] e;
      n = m_a.size();
      chk($sformatf("%s_count", tag), got_d.size(), n * 5);
      for (int i = 0; i < got_d.size() && i < n * 5; i++) begin
         pt = i / 5;
         w  = i % 5;
         case (w)
            0:       e = {16'hA55A, 8'h00, pt[7:0]};
            1:       e = m_a[pt];
            2:       e = m_b[pt];
            3:       e = m_m[pt];
            default: e = m_p[pt];
         endcase
         chk($sformatf("%s_w%0d", tag, i), {got_l[i], got_d[i]}, {(i == n * 5 - 1), e});
      end
   endtask

   task automatic three_points();
      capture(8'd0, 10, 20, 30, -1, 1'b0);
      capture(8'd1, 11, 21, 31, -2, 1'b0);
      capture(8'd2, 12, 22, 32, -3, 1'b0);
   endtask

   initial begin
      int  accepted;
      bit  hit;
      bit  seen;
      areset_n = 1'b0; fin2 = 1'b0; fin = 1'b0; address_mem = '0;
      MODULOA = '0; MODULOB = '0; MODULO = '0; PHASE = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_outputs", {out_data, out_valid, out_last, busy, point_count, overflow, seq_err, sweep_done}, 0);
      areset_n = 1'b1;
      tick();

      // basic 3-point sweep, always ready
      three_points();
      chk("t1_pc", point_count, 3);
      pulse_fin();
      chk("t1_lat_busy", busy, 1);
      chk("t1_lat_valid", out_valid, 0);
      run_stream("t1", 1'b0);
      check_stream("t1");
      if (got_d.size() == 15) begin
         chk("t1_first", got_d[0], 32'hA55A0000);
         chk("t1_phase2", got_d[14], 32'hFFFFFFFD);
      end
      clear_model();

      // same sweep under random backpressure
      three_points();
      pulse_fin();
      run_stream("t2", 1'b1);
      check_stream("t2");
      clear_model();
      chk("t2_flags", {overflow, seq_err}, 0);

      // out-of-sequence address still lands in slot 0
      capture(8'd5, 100, -200, 300, -400, 1'b0);
      chk("t4_seq_err", seq_err, 1);
      pulse_fin();
      run_stream("t4", 1'b0);
      check_stream("t4");
      clear_model();
      chk("t4_sticky", {seq_err, overflow}, 2'b10);

      // fin together with the first capture
      capture(8'd0, 7, 8, 9, -10, 1'b1);
      chk("t5_busy", busy, 1);
      run_stream("t5", 1'b0);
      check_stream("t5");
      clear_model();

      // fin with nothing captured
      fin = 1'b1;
      tick();
      fin  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seen = seen | out_valid | busy;
         tick();
      end
      chk("t5_empty_fin", {seen, point_count}, 0);

      // fill to capacity, then one more
      for (int i = 0; i < 200; i++)
         capture(8'(i), i, -i, i * 1000, 32'h10000000 + i, 1'b0);
      chk("t3_pc_full", {overflow, point_count}, {1'b0, 9'd200});
      capture(8'd200, 1, 2, 3, 4, 1'b0);
      chk("t3_overflow", {overflow, point_count}, {1'b1, 9'd200});
      pulse_fin();
      run_stream("t3", 1'b0);
      check_stream("t3");
      if (got_d.size() == 1000)
         chk("t3_last_hdr", got_d[995], 32'hA55A00C7);
      clear_model();

      // reset while the 7th word is presented
      three_points();
      pulse_fin();
      accepted = 0;
      hit      = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 200 && !hit; i++) begin
         tick();
         if (out_valid) begin
            if (accepted == 6) hit = 1'b1;
            else accepted++;
         end
      end
      chk("t6_reached", hit, 1);
      chk("t6_word7", out_data, 32'd11);
      areset_n = 1'b0;
      tick();
      chk("t6_after_rst", {out_valid, out_last, busy, point_count, overflow, seq_err}, 0);
      areset_n = 1'b1;
      tick();
      clear_model();
      capture(8'd0, -5, 6, -7, 8, 1'b0);
      pulse_fin();
      run_stream("t6", 1'b0);
      check_stream("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sweep_result_buffer.md
Name: sweep_result_buffer

Overview:
Sits directly downstream of the sweep control path. It captures the per-frequency-point measurement results (MODULOA, MODULOB, MODULO, PHASE) on each fin2 strobe and stores them in on-chip RAM, one slot per point. When the sweep-complete strobe fin arrives, it streams the stored sweep out as 32-bit words over a valid/ready interface, for the host-link/DMA stage.

Parameters:
N_POINTS, 200, number of frequency points per sweep (RAM depth)
ADDR_WIDTH, 8, width of point index; 2**ADDR_WIDTH >= N_POINTS
HDR_TAG, 16'hA55A, upper 16 bits of each point's header word

Ports:
clk125  input  1  system clock (all logic on rising edge)
areset_n  input  1  reset, synchronous, active-low
fin2  input  1  one-cycle strobe: measurement results valid this cycle
fin  input  1  one-cycle strobe: sweep finished
address_mem  input  8  point index of the current measurement
MODULOA  input  32 signed  amplitude channel A
MODULOB  input  32 signed  amplitude channel B
MODULO  input  32 signed  amplitude ratio metric
PHASE  input  32 signed  phase metric
out_data  output  32  stream word
out_valid  output  1  stream word valid
out_ready  input  1  downstream accept
out_last  output  1  marks final word of sweep
busy  output  1  high while in STREAM states
point_count  output  ADDR_WIDTH+1  points captured in current sweep
overflow  output  1  sticky: a fin2 was dropped
seq_err  output  1  sticky: address_mem != point_count at capture
sweep_done  output  1  one-cycle pulse after last word accepted

Behaviour:
- Reset (areset_n low at a clock edge): FSM -> COLLECT; out_data=0, out_valid=0, out_last=0, busy=0, point_count=0, overflow=0, seq_err=0, sweep_done=0. RAM contents are not cleared. Reset mid-stream aborts the stream immediately; no out_last is emitted.
- Storage: four parallel RAMs of N_POINTS x 32 (A, B, MOD, PH), all written in the same cycle at address point_count; single read address shared by all four.
- FSM states: COLLECT, RD (issue RAM read), SHOW (present word), DONE.
- COLLECT, capture on fin2:
  - If point_count < N_POINTS: write all four RAMs and increment point_count.
  - If address_mem != point_count[ADDR_WIDTH-1:0] at that cycle, set seq_err. The data is still written at point_count.
  - If point_count == N_POINTS: drop the data and set overflow.
- COLLECT, on fin:
  - If point_count > 0 (after any same-cycle capture): go to RD with rd_idx=0, wsel=0, busy=1.
  - If point_count == 0: fin is ignored.
- fin and fin2 in the same cycle: the capture happens first, and that point is included in the stream.
- Per-point word order, 5 words, wsel 0..4:
  - word0 = {HDR_TAG, 8'h00, rd_idx[7:0]}
  - word1 = MODULOA
  - word2 = MODULOB
  - word3 = MODULO
  - word4 = PHASE
- RD: drives the RAM address rd_idx for one cycle (1-cycle read latency), then goes to SHOW.
- SHOW:
  - out_valid=1. out_data and out_last are registered and stay stable until out_ready is seen with out_valid.
  - On handshake: if wsel<4, wsel++ and return to RD; if wsel==4, set wsel=0, rd_idx++ and return to RD.
  - The handshake on word4 of rd_idx == point_count-1 goes to DONE.
  - out_last=1 only on that final word.
- Throughput: at most one word per 2 cycles; out_valid drops for the RD cycle between words.
- DONE (1 cycle): sweep_done=1, point_count=0, busy=0, then back to COLLECT. overflow and seq_err remain set until reset.
- Latency: first out_valid appears 2 cycles after the fin edge (fin edge -> RD -> SHOW).
- fin2 or fin during RD/SHOW/DONE: ignored. A fin2 here also sets overflow.
- out_ready may be held high or low indefinitely; backpressure never loses or reorders words.

Test Plan:
- Reset, then 3 fin2 strobes with address_mem 0,1,2 and MODULOA=10,11,12, MODULOB=20..22, MODULO=30..32, PHASE=-1,-2,-3; then fin with out_ready=1 -> 15 words, first = 32'hA55A0000, PHASE word of point 2 = 32'hFFFFFFFD, out_last only on word 15, sweep_done one cycle later, point_count back to 0.
- Same stimulus with out_ready toggling pseudo-randomly -> identical 15-word sequence, out_data stable while valid && !ready.
- 200 captures, then a 201st fin2, then fin -> overflow=1, exactly 1000 words streamed, last header = 32'hA55A00C7.
- fin2 with address_mem=5 while point_count=0 -> seq_err=1, data stored at slot 0 and streamed with header index 0.
- fin and fin2 in the same cycle as the 1st capture -> stream of 5 words for that point; fin with point_count=0 -> no out_valid, busy stays 0.
- areset_n low during SHOW of word 7 -> next cycle out_valid=0, busy=0, point_count=0; a subsequent 1-point sweep streams normally.
